crossing_arbiter: RTL and testbench

Two-requester phase controller that shares one exclusive resource (a crossing/output channel) between sides A and B. Sequences IDLE → GREEN → YELLOW → ALL_RED with a minimum dwell, a fixed clearance interval and round-robin tie-breaking. It sits upstream of the design's 1-bit state register and drives `owner`, the registered "who holds the resource" bit, plus the per-side grant and warning outputs.

---
 rtl/crossing_arbiter_pkg.sv | 29 ++
 rtl/crossing_arbiter_phase_timer.sv | 39 +++
 rtl/crossing_arbiter.sv | 159 +++++++++++++++
 tb/tb_crossing_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/crossing_arbiter_pkg.sv
// Shared encodings for the crossing arbiter: phase typedef, owner encodings and
// the IDLE arbitration helper.
package crossing_arbiter_pkg;

    // Phase encoding is visible on the `phase` output, so values are fixed.
    typedef enum logic [1:0] {
        PH_IDLE    = 2'b00,
        PH_GREEN   = 2'b01,
        PH_YELLOW  = 2'b10,
        PH_ALL_RED = 2'b11
    } phase_e;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    // Pick the next holder from the sampled requests; ties go to prio.
    function automatic logic pick_owner(input logic ra, input logic rb, input logic prio);
        logic sel;
        if (ra && rb) begin
            sel = prio;
        end else if (rb) begin
            sel = OWN_B;
        end else begin
            sel = OWN_A;
        end
        return sel;
    endfunction

endpackage

// File: rtl/crossing_arbiter_phase_timer.sv
// Phase dwell timer: saturating up-counter cleared on every phase entry, with a
// terminal compare against a per-phase limit supplied by the FSM.
module phase_timer
    import crossing_arbiter_pkg::*;
#(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk_main,
    input  logic             reset,
    input  logic             clear,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear on phase entry, otherwise count up and hold at all-ones.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_q != '1) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_main) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q >= limit);

endmodule

// File: rtl/crossing_arbiter.sv
// Two-requester phase controller sharing one exclusive resource between sides
// A and B: IDLE -> GREEN -> YELLOW -> ALL_RED with minimum dwell, fixed
// clearance and round-robin tie-break.
// Optional feature macro: STARVE_LIMIT_EN (bounds GREEN to MAX_GREEN cycles
// when the other side is waiting).
module crossing_arbiter
    import crossing_arbiter_pkg::*;
#(
    parameter int unsigned MIN_GREEN = 8,
    parameter int unsigned YELLOW    = 3,
    parameter int unsigned MAX_GREEN = 32,
    parameter int unsigned CNT_W     = 6
) (
    input  logic       clk_main,
    input  logic       reset,
    input  logic       req_a,
    input  logic       req_b,
    output logic       grant_a,
    output logic       grant_b,
    output logic       yellow,
    output logic       owner,
    output logic [1:0] phase
);

    // Elaboration-time parameter range checks.
    if (MIN_GREEN < 1 || MIN_GREEN >= (32'd1 << CNT_W)) begin : g_bad_min_green
        $error("crossing_arbiter: MIN_GREEN out of range 1..2^CNT_W-1");
    end
    if (YELLOW < 1 || YELLOW >= (32'd1 << CNT_W)) begin : g_bad_yellow
        $error("crossing_arbiter: YELLOW out of range 1..2^CNT_W-1");
    end
`ifdef STARVE_LIMIT_EN
    if (MAX_GREEN <= MIN_GREEN || MAX_GREEN >= (32'd1 << CNT_W)) begin : g_bad_max_green
        $error("crossing_arbiter: MAX_GREEN must exceed MIN_GREEN and be below 2^CNT_W");
    end
`endif

    // Timer compares against limit-1 because the count starts at 0 on entry.
    localparam logic [CNT_W-1:0] MIN_LIM = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_LIM = CNT_W'(YELLOW - 1);
`ifdef STARVE_LIMIT_EN
    localparam logic [CNT_W-1:0] MAX_LIM = CNT_W'(MAX_GREEN - 1);
`endif

    phase_e           phase_q;
    phase_e           phase_d;
    logic             owner_q;
    logic             owner_d;
    logic             prio_q;
    logic             prio_d;
    logic             grant_a_q;
    logic             grant_b_q;
    logic             yellow_q;
    logic             own_req;
    logic [CNT_W-1:0] timer_lim;
    logic             timer_done;
    logic             timer_clear;
`ifdef STARVE_LIMIT_EN
    logic             oth_req;
`endif

    assign own_req = (owner_q == OWN_B) ? req_b : req_a;
`ifdef STARVE_LIMIT_EN
    assign oth_req = (owner_q == OWN_B) ? req_a : req_b;
`endif

    // Next-state logic: arbitration in IDLE, dwell/clearance exits elsewhere.
    always_comb begin
        phase_d   = phase_q;
        owner_d   = owner_q;
        prio_d    = prio_q;
        timer_lim = '0;
        unique case (phase_q)
            PH_IDLE: begin
                if (req_a || req_b) begin
                    phase_d = PH_GREEN;
                    owner_d = pick_owner(req_a, req_b, prio_q);
                end
            end
            PH_GREEN: begin
`ifdef STARVE_LIMIT_EN
                // Both sides asking: only the MAX_GREEN bound can end the grant.
                // MAX_GREEN > MIN_GREEN, so the minimum dwell is still honoured.
                if (own_req && oth_req) begin
                    timer_lim = MAX_LIM;
                    if (timer_done) begin
                        phase_d = PH_YELLOW;
                        prio_d  = ~owner_q;
                    end
                end else begin
                    timer_lim = MIN_LIM;
                    if (timer_done && !own_req) begin
                        phase_d = PH_YELLOW;
                        prio_d  = ~owner_q;
                    end
                end
`else
                timer_lim = MIN_LIM;
                if (timer_done && !own_req) begin
                    phase_d = PH_YELLOW;
                    prio_d  = ~owner_q;
                end
`endif
            end
            PH_YELLOW: begin
                timer_lim = YEL_LIM;
                if (timer_done) begin
                    phase_d = PH_ALL_RED;
                end
            end
            PH_ALL_RED: begin
                phase_d = PH_IDLE;
            end
            default: begin
                phase_d = PH_IDLE;
            end
        endcase
    end

    // Every phase change restarts the dwell count.
    assign timer_clear = (phase_d != phase_q);

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk_main (clk_main),
        .reset    (reset),
        .clear    (timer_clear),
        .limit    (timer_lim),
        .done     (timer_done)
    );

    // State and registered outputs; outputs decode the next phase/owner so they
    // line up with the registered phase.
    always_ff @(posedge clk_main) begin
        if (reset) begin
            phase_q   <= PH_IDLE;
            owner_q   <= OWN_A;
            prio_q    <= OWN_A;
            grant_a_q <= 1'b0;
            grant_b_q <= 1'b0;
            yellow_q  <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            owner_q   <= owner_d;
            prio_q    <= prio_d;
            grant_a_q <= (phase_d == PH_GREEN) && (owner_d == OWN_A);
            grant_b_q <= (phase_d == PH_GREEN) && (owner_d == OWN_B);
            yellow_q  <= (phase_d == PH_YELLOW);
        end
    end

    assign grant_a = grant_a_q;
    assign grant_b = grant_b_q;
    assign yellow  = yellow_q;
    assign owner   = owner_q;
    assign phase   = phase_q;

endmodule

// File: tb/tb_crossing_arbiter.sv
// Directed bench for crossing_arbiter with MIN_GREEN=4, YELLOW=2, MAX_GREEN=8.
// Observed vector is {grant_a, grant_b, yellow, owner, phase[1:0]}.
module tb_crossing_arbiter;

    logic       clk_main;
    logic       reset;
    logic       req_a;
    logic       req_b;
    logic       grant_a;
    logic       grant_b;
    logic       yellow;
    logic       owner;
    logic [1:0] phase;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [5:0] V_IDLE_A = 6'b000000;
    localparam logic [5:0] V_GA     = 6'b100001;
    localparam logic [5:0] V_GB     = 6'b010101;
    localparam logic [5:0] V_YA     = 6'b001010;
    localparam logic [5:0] V_RA     = 6'b000011;

    crossing_arbiter #(
        .MIN_GREEN (4),
        .YELLOW    (2),
        .MAX_GREEN (8),
        .CNT_W     (6)
    ) dut (
        .clk_main (clk_main),
        .reset    (reset),
        .req_a    (req_a),
        .req_b    (req_b),
        .grant_a  (grant_a),
        .grant_b  (grant_b),
        .yellow   (yellow),
        .owner    (owner),
        .phase    (phase)
    );

    initial clk_main = 1'b0;
    always #5 clk_main = ~clk_main;

    task automatic step();
        @(posedge clk_main);
        #1;
    endtask

    task automatic chk(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        obs = {grant_a, grant_b, yellow, owner, phase};
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        step();
        reset = 1'b0;
    endtask

    initial begin
        // Reset held with both requests high.
        reset = 1'b1;
        req_a = 1'b1;
        req_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset_hold", V_IDLE_A);
        end
        reset = 1'b0;
        chk("first_after_release", V_IDLE_A);
        step();
        chk("grant_after_release", V_GA);
        do_reset();
        chk("reset_from_green", V_IDLE_A);

        // Single-cycle req_a pulse.
        req_a = 1'b1;
        step();
        req_a = 1'b0;
        chk("pulse_green0", V_GA);
        for (int i = 1; i < 4; i++) begin
            step();
            chk("pulse_green", V_GA);
        end
        step();
        chk("pulse_yellow1", V_YA);
        step();
        chk("pulse_yellow2", V_YA);
        step();
        chk("pulse_allred", V_RA);
        step();
        chk("pulse_idle", V_IDLE_A);
        step();
        chk("pulse_idle_stay", V_IDLE_A);

        // Both requesting, A drops after 6 grant cycles, B takes over.
        do_reset();
        req_a = 1'b1;
        req_b = 1'b1;
        step();
        chk("tie_green0", V_GA);
        for (int i = 1; i < 6; i++) begin
            step();
            chk("tie_green", V_GA);
        end
        req_a = 1'b0;
        step();
        chk("tie_yellow1", V_YA);
        step();
        chk("tie_yellow2", V_YA);
        step();
        chk("tie_allred", V_RA);
        step();
        chk("tie_idle", V_IDLE_A);
        step();
        chk("tie_grant_b", V_GB);

        // Both held high continuously.
        do_reset();
        req_a = 1'b1;
        req_b = 1'b1;
        step();
`ifdef STARVE_LIMIT_EN
        chk("starve_green0", V_GA);
        for (int i = 1; i < 8; i++) begin
            step();
            chk("starve_green", V_GA);
        end
        step();
        chk("starve_yellow1", V_YA);
        step();
        chk("starve_yellow2", V_YA);
        step();
        chk("starve_allred", V_RA);
        step();
        chk("starve_idle", V_IDLE_A);
        step();
        chk("starve_grant_b", V_GB);
`else
        for (int i = 0; i < 100; i++) begin
            chk("hold_green", V_GA);
            step();
        end
`endif

        // Reset during the first YELLOW cycle.
        do_reset();
        req_a = 1'b1;
        step();
        req_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("ry_green", V_GA);
            step();
        end
        chk("ry_yellow1", V_YA);
        reset = 1'b1;
        req_a = 1'b1;
        req_b = 1'b1;
        step();
        chk("ry_after_reset", V_IDLE_A);
        reset = 1'b0;
        step();
        chk("ry_grant_a", V_GA);

        // req_a re-asserted in YELLOW with req_b low: sequence completes, A again.
        do_reset();
        req_a = 1'b1;
        step();
        req_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rq_green", V_GA);
            step();
        end
        chk("rq_yellow1", V_YA);
        req_a = 1'b1;
        step();
        chk("rq_yellow2", V_YA);
        step();
        chk("rq_allred", V_RA);
        step();
        chk("rq_idle", V_IDLE_A);
        step();
        chk("rq_grant_a", V_GA);

        // Same, but req_b also high: B wins on prio.
        do_reset();
        req_a = 1'b1;
        step();
        req_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rqb_green", V_GA);
            step();
        end
        chk("rqb_yellow1", V_YA);
        req_a = 1'b1;
        req_b = 1'b1;
        step();
        chk("rqb_yellow2", V_YA);
        step();
        chk("rqb_allred", V_RA);
        step();
        chk("rqb_idle", V_IDLE_A);
        step();
        chk("rqb_grant_b", V_GB);

        do_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
